// File: rtl/gravity_tick_ctrl.sv
// -----------------------------------------------------------------------------
// gravity_tick_ctrl
//
// Fall-rate controller for a falling-block game. It turns the rising edges of
// an externally divided clock (clkdiv) into single-cycle fall_tick pulses,
// and provides a soft-drop mode with its own fixed tick period. It also
// supports pausing and a level counter driven by cleared lines. The current
// level selects the divider bound (upperbound) that is fed back to the
// divider.
//
// Ports
//   clk          in   1   system clock; also clocks the divider
//   rst_n        in   1   asynchronous active-low reset
//   clkdiv       in   1   divided clock from the divider, synchronous to clk
//   start        in   1   1-cycle pulse: begin a new game (used in IDLE only)
//   game_over    in   1   1-cycle pulse: end the current game
//   pause        in   1   level: hold gravity while high
//   soft_drop    in   1   level: fast fall while high
//   lines_valid  in   1   1-cycle strobe qualifying lines_cnt
//   lines_cnt    in   3   lines cleared by the last lock, 0..4
//   upperbound   out  32  registered divider bound derived from level
//   fall_tick    out  1   1-cycle pulse: move the piece down one row
//   level        out  4   current level, 0..MAX_LEVEL
//   total_lines  out  16  lines cleared this game, saturating at 16'hFFFF
//   running      out  1   high only in the RUNNING state
//
// Handshake note: there is no back-pressure anywhere in this block.
// lines_valid is a one-cycle qualifier: lines_cnt is consumed on every clock
// edge where lines_valid is high and the game is not IDLE. fall_tick is a
// one-cycle pulse that the consumer must act on in the cycle it is seen.
// -----------------------------------------------------------------------------
module gravity_tick_ctrl #(
    parameter int unsigned BASE_BOUND      = 25_000_000,
    parameter int unsigned BOUND_STEP      = 2_000_000,
    parameter int unsigned MIN_BOUND       = 2_500_000,
    parameter int unsigned LINES_PER_LEVEL = 10,
    parameter int unsigned MAX_LEVEL       = 9,
    parameter int unsigned SOFT_PERIOD     = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clkdiv,
    input  logic        start,
    input  logic        game_over,
    input  logic        pause,
    input  logic        soft_drop,
    input  logic        lines_valid,
    input  logic [2:0]  lines_cnt,
    output logic [31:0] upperbound,
    output logic        fall_tick,
    output logic [3:0]  level,
    output logic [15:0] total_lines,
    output logic        running
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;

    // ------------------------------------------------------------------
    // Parameter-derived constants, sized to the datapaths that use them
    // ------------------------------------------------------------------
    localparam int unsigned CNT_W = (SOFT_PERIOD > 2) ? $clog2(SOFT_PERIOD) : 1;

    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_PERIOD - 1);
    localparam logic [31:0]      BASE_U    = 32'(BASE_BOUND);
    localparam logic [31:0]      STEP_U    = 32'(BOUND_STEP);
    localparam logic [31:0]      MIN_U     = 32'(MIN_BOUND);
    localparam logic [15:0]      LPL_U     = 16'(LINES_PER_LEVEL);
    localparam logic [3:0]       MAX_LVL   = 4'(MAX_LEVEL);

    // ------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             clkdiv_q;
    logic [CNT_W-1:0] soft_cnt;
    logic             soft_fire;
    logic [15:0]      lines_in_level;

    // Combinational helpers
    logic        div_rise;
    logic        is_running;
    logic        stay_running;
    logic        soft_active;
    logic        grav_evt;
    logic        game_start;
    logic        lines_accept;
    logic [16:0] total_sum;
    logic [15:0] lil_sum;
    logic [35:0] step_total;
    logic [31:0] bound_diff;
    logic [31:0] bound_nxt;

    // ------------------------------------------------------------------
    // Next-state logic. game_over wins over pause; start only matters in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (game_over) begin
                    state_nxt = ST_IDLE;
                end else if (pause) begin
                    state_nxt = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (game_over) begin
                    state_nxt = ST_IDLE;
                end else if (!pause) begin
                    state_nxt = ST_RUNNING;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign is_running = (state == ST_RUNNING);
    assign running    = is_running;

    // A tick is only issued if the machine is RUNNING now and stays RUNNING
    // across this edge. This suppresses a tick that is pending when pause
    // or game_over arrives, so fall_tick is never seen outside RUNNING.
    assign stay_running = is_running && (state_nxt == ST_RUNNING);

    // clkdiv_q follows clkdiv in every state. A rise seen outside RUNNING is
    // therefore consumed and never replayed later.
    assign div_rise    = clkdiv && !clkdiv_q;
    assign soft_active = is_running && soft_drop;
    assign grav_evt    = div_rise && !soft_drop;

    // ------------------------------------------------------------------
    // State register, edge detector, soft-drop timer, tick generation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            clkdiv_q  <= 1'b0;
            soft_cnt  <= '0;
            soft_fire <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            state    <= state_nxt;
            clkdiv_q <= clkdiv;

            // Soft-drop timer: free-runs while active and wraps at
            // SOFT_PERIOD-1. Any break in soft_drop or RUNNING restarts it.
            if (soft_active) begin
                if (soft_cnt == SOFT_LAST) begin
                    soft_cnt <= '0;
                end else begin
                    soft_cnt <= soft_cnt + CNT_W'(1);
                end
            end else begin
                soft_cnt <= '0;
            end

            // The wrap is registered once before it reaches fall_tick. This
            // puts the first soft tick SOFT_PERIOD+1 cycles after soft_drop
            // is first sampled high, and the later ticks SOFT_PERIOD apart.
            soft_fire <= soft_active && (soft_cnt == SOFT_LAST);

            fall_tick <= stay_running && (grav_evt || soft_fire);
        end
    end

    // ------------------------------------------------------------------
    // Line accounting and level counter
    // ------------------------------------------------------------------
    assign game_start   = (state == ST_IDLE) && start;
    assign lines_accept = lines_valid && (state != ST_IDLE);
    assign total_sum    = {1'b0, total_lines} + {14'd0, lines_cnt};
    assign lil_sum      = lines_in_level + {13'd0, lines_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level          <= 4'd0;
            total_lines    <= 16'd0;
            lines_in_level <= 16'd0;
        end else if (game_start) begin
            level          <= 4'd0;
            total_lines    <= 16'd0;
            lines_in_level <= 16'd0;
        end else if (lines_accept) begin
            total_lines <= total_sum[16] ? 16'hFFFF : total_sum[15:0];

            if (level < MAX_LVL) begin
                // lines_cnt is at most 4 and LINES_PER_LEVEL is at least 4,
                // so one strobe can never be worth more than one level.
                if (lil_sum >= LPL_U) begin
                    level          <= level + 4'd1;
                    lines_in_level <= lil_sum - LPL_U;
                end else begin
                    lines_in_level <= lil_sum;
                end
            end else begin
                // At the top level the remainder is meaningless; keep it at 0.
                lines_in_level <= 16'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Divider bound: BASE - level*STEP, clamped at MIN_BOUND. The product
    // is kept 36 bits wide so a large step cannot wrap before the
    // underflow test.
    // ------------------------------------------------------------------
    always_comb begin
        step_total = 36'(level) * 36'(STEP_U);
        bound_diff = 32'd0;
        bound_nxt  = MIN_U;
        if (step_total <= {4'd0, BASE_U}) begin
            bound_diff = BASE_U - step_total[31:0];
            if (bound_diff >= MIN_U) begin
                bound_nxt = bound_diff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upperbound <= BASE_U;
        end else begin
            upperbound <= bound_nxt;
        end
    end

endmodule
